// File: rtl/verificacion_pin_if.sv
// verificacion_pin_if: card/PIN-entry bus between the cashier front end and the
// PIN-verification stage. The master drives card presence, stored PIN and
// keypad digits; the slave returns the verification outcome.
interface verificacion_pin_if #(
  parameter int DIGITOS = 4
);
  logic                   tarjeta_recibida;
  logic [4*DIGITOS-1:0]   pin;
  logic [3:0]             digito;
  logic                   digito_stb;
  logic                   pin_correcto;
  logic                   pin_incorrecto;
  logic                   advertencia;
  logic                   bloqueo;
  logic [1:0]             intentos;

  modport master (
    output tarjeta_recibida, pin, digito, digito_stb,
    input  pin_correcto, pin_incorrecto, advertencia, bloqueo, intentos
  );

  modport slave (
    input  tarjeta_recibida, pin, digito, digito_stb,
    output pin_correcto, pin_incorrecto, advertencia, bloqueo, intentos
  );
endinterface

// File: rtl/verificacion_pin.sv
// verificacion_pin: collects BCD PIN digits after card insertion, compares the
// full entry against the card's stored PIN and allows a bounded number of
// attempts before retaining the card. All outputs are registered.
module verificacion_pin #(
  parameter int DIGITOS      = 4,
  parameter int MAX_INTENTOS = 3
) (
  input logic               clk,
  input logic               reset,
  verificacion_pin_if.slave bus
);

  localparam int W  = 4 * DIGITOS;
  localparam int CW = $clog2(DIGITOS + 1);

  localparam logic [CW-1:0] ULTIMO_DIGITO = CW'(DIGITOS - 1);
  localparam logic [1:0]    INTENTOS_MAX  = 2'(MAX_INTENTOS);
  localparam logic [1:0]    INTENTOS_AVISO = 2'(MAX_INTENTOS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ESPERA_PIN,
    VERIFICA,
    AUTORIZADO,
    BLOQUEADO
  } estado_t;

  estado_t         state_reg, state_next;
  logic [W-1:0]    entry_reg, entry_next;
  logic [CW-1:0]   cuenta_reg, cuenta_next;
  logic [1:0]      intentos_reg, intentos_next;
  logic            advertencia_reg, advertencia_next;
  logic            bloqueo_reg, bloqueo_next;
  logic            pin_correcto_reg, pin_correcto_next;
  logic            pin_incorrecto_reg, pin_incorrecto_next;
  logic [1:0]      intentos_inc;
  logic            digito_valido;

  // State and all registered outputs; reset drops everything back to an idle, card-less view.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg          <= IDLE;
      entry_reg          <= '0;
      cuenta_reg         <= '0;
      intentos_reg       <= '0;
      advertencia_reg    <= 1'b0;
      bloqueo_reg        <= 1'b0;
      pin_correcto_reg   <= 1'b0;
      pin_incorrecto_reg <= 1'b0;
    end else begin
      state_reg          <= state_next;
      entry_reg          <= entry_next;
      cuenta_reg         <= cuenta_next;
      intentos_reg       <= intentos_next;
      advertencia_reg    <= advertencia_next;
      bloqueo_reg        <= bloqueo_next;
      pin_correcto_reg   <= pin_correcto_next;
      pin_incorrecto_reg <= pin_incorrecto_next;
    end
  end

  // Next-state and next-output logic; card removal wins over strobes and comparison.
  always_comb begin
    state_next          = state_reg;
    entry_next          = entry_reg;
    cuenta_next         = cuenta_reg;
    intentos_next       = intentos_reg;
    advertencia_next    = advertencia_reg;
    bloqueo_next        = bloqueo_reg;
    pin_correcto_next   = pin_correcto_reg;
    pin_incorrecto_next = 1'b0;
    intentos_inc        = intentos_reg + 2'd1;
    digito_valido       = bus.digito_stb && (bus.digito <= 4'd9);

    case (state_reg)
      IDLE: begin
        if (bus.tarjeta_recibida) begin
          state_next = ESPERA_PIN;
        end
      end

      ESPERA_PIN: begin
        if (!bus.tarjeta_recibida) begin
          state_next = IDLE;
        end else if (digito_valido) begin
          entry_next  = {entry_reg[W-5:0], bus.digito};
          cuenta_next = cuenta_reg + 1'b1;
          if (cuenta_reg == ULTIMO_DIGITO) begin
            state_next = VERIFICA;
          end
        end
      end

      VERIFICA: begin
        if (!bus.tarjeta_recibida) begin
          state_next = IDLE;
        end else if (entry_reg == bus.pin) begin
          state_next        = AUTORIZADO;
          pin_correcto_next = 1'b1;
        end else begin
          intentos_next       = intentos_inc;
          pin_incorrecto_next = 1'b1;
          if (intentos_inc == INTENTOS_AVISO) begin
            advertencia_next = 1'b1;
          end
          if (intentos_inc == INTENTOS_MAX) begin
            state_next   = BLOQUEADO;
            bloqueo_next = 1'b1;
          end else begin
            state_next  = ESPERA_PIN;
            entry_next  = '0;
            cuenta_next = '0;
          end
        end
      end

      AUTORIZADO: begin
        pin_correcto_next = 1'b1;
        if (!bus.tarjeta_recibida) begin
          state_next = IDLE;
        end
      end

      BLOQUEADO: begin
        // Card is retained: nothing but reset leaves this state.
        bloqueo_next = 1'b1;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Whatever path leads to IDLE, the session context is discarded on that same edge.
    if (state_next == IDLE) begin
      entry_next        = '0;
      cuenta_next       = '0;
      intentos_next     = '0;
      advertencia_next  = 1'b0;
      pin_correcto_next = 1'b0;
    end
  end

  assign bus.pin_correcto   = pin_correcto_reg;
  assign bus.pin_incorrecto = pin_incorrecto_reg;
  assign bus.advertencia    = advertencia_reg;
  assign bus.bloqueo        = bloqueo_reg;
  assign bus.intentos       = intentos_reg;

endmodule

// File: tb/tb_verificacion_pin.sv
// tb_verificacion_pin: directed scenarios plus randomized traffic. The stimulus
// side runs a session-level model and queues expected results; a monitor on the
// falling edge pops and compares whatever the DUT presents.
module tb_verificacion_pin;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  verificacion_pin_if #(.DIGITOS(4)) bus ();

  verificacion_pin #(.DIGITOS(4), .MAX_INTENTOS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        ok;
    logic [1:0]  intentos;
    logic        adv;
    logic        blk;
    int unsigned tc;
  } ev_t;

  typedef struct packed {
    logic        pc;
    logic        inc;
    logic        adv;
    logic        blk;
    logic [1:0]  intentos;
    int unsigned tc;
  } lvl_t;

  ev_t         ev_q[$];
  lvl_t        lvl_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  bit          done = 1'b0;
  bit          fin = 1'b0;
  logic        prev_pc = 1'b0;
  ev_t         got_e;
  lvl_t        got_l;

  // Session model: card seated, authorised, retained, result pending, failures so far.
  bit          seated, authorised, blocked, pending, inc_now;
  int          attempts;
  logic [3:0]  entered[$];
  logic [15:0] stored;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void go_idle();
    seated     = 1'b0;
    authorised = 1'b0;
    attempts   = 0;
    entered.delete();
  endfunction

  // Applies one sampled cycle of inputs to the model.
  function automatic void model_step(input bit t, input bit s, input logic [3:0] d);
    logic [15:0] v;
    ev_t e;
    inc_now = 1'b0;
    if (blocked) return;
    if (pending) begin
      pending = 1'b0;
      if (!t) begin
        go_idle();
        return;
      end
      v = '0;
      foreach (entered[k]) v = (v << 4) | 16'(entered[k]);
      entered.delete();
      if (v == stored) begin
        authorised = 1'b1;
      end else begin
        attempts = attempts + 1;
        inc_now  = 1'b1;
        if (attempts == 3) blocked = 1'b1;
      end
      e.ok       = authorised;
      e.intentos = 2'(attempts);
      e.adv      = (attempts >= 2);
      e.blk      = blocked;
      e.tc       = cyc + 1;
      ev_q.push_back(e);
      return;
    end
    if (!t) begin
      go_idle();
      return;
    end
    if (!seated) begin
      seated = 1'b1;
      return;
    end
    if (authorised) return;
    if (s && d <= 4'd9) begin
      entered.push_back(d);
      if (entered.size() == 4) pending = 1'b1;
    end
  endfunction

  task automatic step(input bit t, input bit s, input logic [3:0] d);
    lvl_t e;
    bus.tarjeta_recibida = t;
    bus.digito_stb       = s;
    bus.digito           = d;
    bus.pin              = stored;
    model_step(t, s, d);
    e.pc       = authorised;
    e.inc      = inc_now;
    e.adv      = (attempts >= 2);
    e.blk      = blocked;
    e.intentos = 2'(attempts);
    e.tc       = cyc + 1;
    lvl_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic [15:0] digs);
    for (int k = 3; k >= 0; k--) step(1'b1, 1'b1, digs[4*k +: 4]);
  endtask

  task automatic do_reset();
    lvl_t z;
    reset                = 1'b0;
    bus.tarjeta_recibida = 1'b0;
    bus.digito_stb       = 1'b0;
    bus.digito           = 4'd0;
    go_idle();
    blocked = 1'b0;
    pending = 1'b0;
    inc_now = 1'b0;
    ev_q.delete();
    lvl_q.delete();
    z    = '0;
    z.tc = cyc;
    lvl_q.push_back(z);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: result events against the expected-result queue, levels against the per-cycle queue.
  always @(negedge clk) begin
    if (ev_q.size() > 0 && ev_q[0].tc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_result: expected result at cycle %0d, still missing at cycle %0d", ev_q[0].tc, cyc);
      void'(ev_q.pop_front());
    end
    if (bus.pin_incorrecto || (bus.pin_correcto && !prev_pc)) begin
      checks++;
      if (ev_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: cycle %0d got pc=%0b inc=%0b intentos=%0d, required no result",
                 cyc, bus.pin_correcto, bus.pin_incorrecto, bus.intentos);
      end else begin
        got_e = ev_q.pop_front();
        if ({bus.pin_correcto, bus.intentos, bus.advertencia, bus.bloqueo, cyc} !=
            {got_e.ok, got_e.intentos, got_e.adv, got_e.blk, got_e.tc}) begin
          errors++;
          $display("FAIL result: got ok=%0b int=%0d adv=%0b blk=%0b cyc=%0d, required ok=%0b int=%0d adv=%0b blk=%0b cyc=%0d",
                   bus.pin_correcto, bus.intentos, bus.advertencia, bus.bloqueo, cyc,
                   got_e.ok, got_e.intentos, got_e.adv, got_e.blk, got_e.tc);
        end
      end
    end
    if (lvl_q.size() > 0 && lvl_q[0].tc == cyc) begin
      got_l = lvl_q.pop_front();
      checks++;
      if ({bus.pin_correcto, bus.pin_incorrecto, bus.advertencia, bus.bloqueo, bus.intentos} !=
          {got_l.pc, got_l.inc, got_l.adv, got_l.blk, got_l.intentos}) begin
        errors++;
        $display("FAIL levels: cycle %0d got pc=%0b inc=%0b adv=%0b blk=%0b int=%0d, required pc=%0b inc=%0b adv=%0b blk=%0b int=%0d",
                 cyc, bus.pin_correcto, bus.pin_incorrecto, bus.advertencia, bus.bloqueo, bus.intentos,
                 got_l.pc, got_l.inc, got_l.adv, got_l.blk, got_l.intentos);
      end
    end
    if (done && !fin) begin
      fin = 1'b1;
      checks++;
      if (ev_q.size() != 0) begin
        errors++;
        $display("FAIL leftover_results: %0d results never seen, required 0", ev_q.size());
      end
    end
    prev_pc = bus.pin_correcto;
  end

  initial begin
    int          r;
    bit          t, s;
    logic [3:0]  d;

    bus.tarjeta_recibida = 1'b0;
    bus.digito_stb       = 1'b0;
    bus.digito           = 4'd0;
    stored               = 16'h1234;
    bus.pin              = stored;
    seated = 0; authorised = 0; blocked = 0; pending = 0; inc_now = 0; attempts = 0;

    @(posedge clk);
    #1;
    do_reset();

    // Correct PIN on consecutive strobes, then card removal.
    step(1, 0, 0);
    enter(16'h1234);
    step(1, 0, 0); step(1, 0, 0);
    step(0, 0, 0); step(0, 0, 0);

    // One failure, a strobe during the comparison cycle, then the right PIN.
    step(1, 0, 0);
    enter(16'h1235);
    step(1, 1, 4'd1);
    enter(16'h1234);
    step(1, 0, 0); step(1, 0, 0);
    step(0, 0, 0);

    // Card pulled during the comparison cycle: no result, no attempt.
    step(1, 0, 0);
    enter(16'h1235);
    step(0, 1, 4'd1);
    step(0, 0, 0);

    // Three failures: warning, then block that ignores everything.
    step(1, 0, 0);
    repeat (3) begin
      enter(16'h9999);
      step(1, 0, 0);
    end
    step(0, 0, 0); step(0, 1, 4'd1); step(1, 1, 4'd2); step(0, 1, 4'd3);
    do_reset();

    // Non-BCD digits are ignored.
    step(1, 0, 0);
    step(1, 1, 4'd1); step(1, 1, 4'd12); step(1, 1, 4'd2);
    step(1, 1, 4'd15); step(1, 1, 4'd3); step(1, 1, 4'd4);
    step(1, 0, 0); step(1, 0, 0);
    step(0, 0, 0);

    // Partial entry then removal restarts cleanly.
    step(1, 0, 0);
    step(1, 1, 4'd1); step(1, 1, 4'd2);
    step(0, 0, 0);
    step(1, 0, 0);
    enter(16'h1234);
    step(1, 0, 0); step(1, 0, 0);
    step(0, 0, 0);

    // Reset mid-entry restarts the digit count.
    step(1, 0, 0);
    step(1, 1, 4'd1); step(1, 1, 4'd2); step(1, 1, 4'd3);
    do_reset();
    step(1, 0, 0);
    enter(16'h1234);
    step(1, 0, 0); step(1, 0, 0);
    step(0, 0, 0);

    // Randomized sessions.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 3 || (blocked && r < 60)) begin
        do_reset();
      end else begin
        if (!seated && !blocked) begin
          t = ($urandom_range(0, 99) < 30);
          if (!t) begin
            for (int k = 0; k < 4; k++) stored[4*k +: 4] = 4'($urandom_range(0, 9));
          end
        end else begin
          t = ($urandom_range(0, 99) < 97);
        end
        s = ($urandom_range(0, 99) < 60);
        if (entered.size() < 4 && $urandom_range(0, 99) < 55)
          d = stored[(15 - 4 * entered.size()) -: 4];
        else
          d = 4'($urandom_range(0, 15));
        step(t, s, d);
      end
    end

    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
